// File: rtl/modulo_controle_transferencia_rolhas.sv
// Owner of both cork reservoir counts: admits operator loads into the secondary
// reservoir and moves TRANSFER_QTY corks to the main reservoir when it runs low.
module modulo_controle_transferencia_rolhas #(
  parameter int SEC_MAX      = 99,
  parameter int MIN_MAIN     = 5,
  parameter int TRANSFER_QTY = 15,
  parameter int MAIN_INIT    = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       op_load,
  input  logic [6:0] op_qty,
  input  logic       seal_pulse,
  output logic [4:0] main_q,
  output logic [6:0] sec_q,
  output logic [1:0] state,
  output logic       busy,
  output logic       op_ack,
  output logic       op_reject,
  output logic       ro,
  output logic       al_rolhas
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] LOAD     = 2'b01;
  localparam logic [1:0] TRANSFER = 2'b10;

  localparam logic [7:0] SEC_MAX_W   = SEC_MAX[7:0];
  localparam logic [4:0] MIN_MAIN_W  = MIN_MAIN[4:0];
  localparam logic [6:0] XFER_W      = TRANSFER_QTY[6:0];
  localparam logic [4:0] MAIN_INIT_W = MAIN_INIT[4:0];

  logic [6:0] rem;
  logic [6:0] rem_n;
  logic [6:0] sec_n;
  logic [4:0] main_n;
  logic [1:0] state_n;
  logic [7:0] sum;
  logic       main_inc;
  logic       ack_n;
  logic       rej_n;

  // 8-bit sum so a request near SEC_MAX cannot wrap past the admission check
  assign sum = {1'b0, sec_q} + {1'b0, op_qty};

  always_comb begin
    state_n  = state;
    sec_n    = sec_q;
    rem_n    = rem;
    main_inc = 1'b0;
    ack_n    = 1'b0;
    rej_n    = 1'b0;
    case (state)
      IDLE: begin
        if (op_load) begin
          if (sum <= SEC_MAX_W) begin
            state_n = LOAD;
            rem_n   = op_qty;
            ack_n   = 1'b1;
          end else begin
            rej_n = 1'b1;
          end
        end else if (main_q < MIN_MAIN_W && sec_q >= XFER_W) begin
          state_n = TRANSFER;
          rem_n   = XFER_W;
        end
      end
      LOAD: begin
        rej_n = op_load;
        if (rem == 7'd0) begin
          state_n = IDLE;
        end else begin
          sec_n = sec_q + 7'd1;
          rem_n = rem - 7'd1;
        end
      end
      TRANSFER: begin
        rej_n = op_load;
        if (rem == 7'd0) begin
          state_n = IDLE;
        end else begin
          sec_n    = sec_q - 7'd1;
          rem_n    = rem - 7'd1;
          main_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A consumption on the same edge as a transfer increment cancels out
  always_comb begin
    main_n = main_q;
    if (main_inc && !seal_pulse)
      main_n = main_q + 5'd1;
    else if (!main_inc && seal_pulse && main_q != 5'd0)
      main_n = main_q - 5'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      main_q    <= MAIN_INIT_W;
      sec_q     <= 7'd0;
      rem       <= 7'd0;
      op_ack    <= 1'b0;
      op_reject <= 1'b0;
    end else begin
      op_ack    <= 1'b0;
      op_reject <= 1'b0;
      if (enable) begin
        state     <= state_n;
        main_q    <= main_n;
        sec_q     <= sec_n;
        rem       <= rem_n;
        op_ack    <= ack_n;
        op_reject <= rej_n;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign ro        = (main_q == 5'd0);
  assign al_rolhas = (main_q < MIN_MAIN_W) && (sec_q < XFER_W) && (state == IDLE);

endmodule
